// File: rtl/bnn_pkg.sv
// Shared types and constants for the BNN data-SRAM arbiter.
// Owner tags carry an OWN_ prefix and arbiter states an ST_ prefix so their names do not collide.
package bnn_pkg;

    localparam int DSRAM_ADDR_W  = 13;
    localparam int DSRAM_CEN_BIT = 13;
    localparam int DSRAM_WEN_BIT = 14;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PAUSE,
        ST_HOST
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CORE,
        OWN_HOST
    } owner_t;

endpackage

// File: rtl/bnn_dsram_arb.sv
// Single-port data-SRAM arbiter: core has priority, host is guaranteed a slot
// after a bounded wait by pausing the controller for one instruction.
//
// state    | meaning
// ST_IDLE  | core priority, host served when core idle
// ST_PAUSE | controller paused; current core access still honoured
// ST_HOST  | host priority; a colliding core access is dropped
module bnn_dsram_arb
    import bnn_pkg::*;
#(
    parameter int ADDR_W   = DSRAM_ADDR_W,
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W+1:0] core_ctrl,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_rvalid,
    input  logic              ext_pause,
    output logic              core_pause,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_rvalid,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_d,
    output logic              sram_cen,
    output logic              sram_wen,
    input  logic [DATA_W-1:0] sram_q,
    output logic              arb_err
);

    localparam int WCNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WCNT_W-1:0] WCNT_MAX  = WCNT_W'(MAX_WAIT);
    localparam logic [WCNT_W-1:0] WCNT_TRIG = WCNT_W'(MAX_WAIT - 1);

    arb_state_t        state, state_nxt;
    owner_t            owner, owner_nxt;
    logic [WCNT_W-1:0] wcnt;
    logic              core_acc;
    logic              core_wr;
    logic              core_gnt;
    logic              host_xfer;

    assign core_acc = ~core_ctrl[ADDR_W];
    assign core_wr  = ~core_ctrl[ADDR_W+1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            owner   <= OWN_NONE;
            wcnt    <= '0;
            arb_err <= 1'b0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            if (!host_valid || host_xfer)
                wcnt <= '0;
            else if (wcnt != WCNT_MAX)
                wcnt <= wcnt + 1'b1;
            if (state == ST_HOST && core_acc)
                arb_err <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (host_valid && !host_ready && wcnt >= WCNT_TRIG) state_nxt = ST_PAUSE;
            ST_PAUSE: state_nxt = ST_HOST;
            ST_HOST:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Everything combinational is gated by rst so outputs sit at reset values during reset.
    always_comb begin
        core_gnt   = !rst && core_acc && (state != ST_HOST);
        host_ready = !rst && host_valid && (state == ST_HOST || !core_acc);
        host_xfer  = host_ready;
        core_pause = !rst && (ext_pause || state == ST_PAUSE);

        sram_addr = '0;
        sram_d    = '0;
        sram_cen  = 1'b1;
        sram_wen  = 1'b1;
        owner_nxt = OWN_NONE;
        if (core_gnt) begin
            sram_addr = core_ctrl[ADDR_W-1:0];
            sram_d    = core_wdata;
            sram_cen  = 1'b0;
            sram_wen  = ~core_wr;
            if (!core_wr) owner_nxt = OWN_CORE;
        end else if (host_xfer) begin
            sram_addr = host_addr;
            sram_d    = host_wdata;
            sram_cen  = 1'b0;
            sram_wen  = ~host_we;
            if (!host_we) owner_nxt = OWN_HOST;
        end

        core_rvalid = !rst && (owner == OWN_CORE);
        host_rvalid = !rst && (owner == OWN_HOST);
        core_rdata  = core_rvalid ? sram_q : '0;
        host_rdata  = host_rvalid ? sram_q : '0;
    end

endmodule

// File: tb/tb_bnn_dsram_arb.sv
// Directed bench for bnn_dsram_arb with a queue-based scoreboard and a
// behavioural single-port SRAM model.
module tb_bnn_dsram_arb;

    typedef struct {
        logic [12:0] addr;
        logic [15:0] d;
        logic        wen;
    } xfer_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [14:0] core_ctrl;
    logic [15:0] core_wdata;
    logic [15:0] core_rdata;
    logic        core_rvalid;
    logic        ext_pause;
    logic        core_pause;
    logic        host_valid;
    logic        host_ready;
    logic        host_we;
    logic [12:0] host_addr;
    logic [15:0] host_wdata;
    logic [15:0] host_rdata;
    logic        host_rvalid;
    logic [12:0] sram_addr;
    logic [15:0] sram_d;
    logic        sram_cen;
    logic        sram_wen;
    logic [15:0] sram_q = 16'h0;
    logic        arb_err;

    logic [15:0] mem [0:8191];
    logic [15:0] cq[$];
    logic [15:0] hq[$];
    xfer_t       xq[$];
    xfer_t       xe;
    logic [15:0] ce, he;
    int          checks = 0;
    int          failures = 0;

    bnn_dsram_arb dut (
        .clk(clk), .rst(rst),
        .core_ctrl(core_ctrl), .core_wdata(core_wdata),
        .core_rdata(core_rdata), .core_rvalid(core_rvalid),
        .ext_pause(ext_pause), .core_pause(core_pause),
        .host_valid(host_valid), .host_ready(host_ready), .host_we(host_we),
        .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rdata(host_rdata), .host_rvalid(host_rvalid),
        .sram_addr(sram_addr), .sram_d(sram_d), .sram_cen(sram_cen),
        .sram_wen(sram_wen), .sram_q(sram_q), .arb_err(arb_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_wen) mem[sram_addr] <= sram_d;
            else           sram_q <= mem[sram_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic core_idle();
        core_ctrl  = {1'b1, 1'b1, 13'h0};
        core_wdata = 16'h0;
    endtask

    task automatic core_op(input bit wr, input logic [12:0] a, input logic [15:0] d);
        core_ctrl  = {~wr, 1'b0, a};
        core_wdata = d;
    endtask

    // Monitor: pops expectations whenever the DUT presents a transfer or read data.
    always @(negedge clk) begin
        if (core_rvalid) begin
            if (cq.size() == 0) chk("core_rd_unexpected", 1, 0);
            else begin ce = cq.pop_front(); chk("core_rdata", core_rdata, ce); end
        end
        if (host_rvalid) begin
            if (hq.size() == 0) chk("host_rd_unexpected", 1, 0);
            else begin he = hq.pop_front(); chk("host_rdata", host_rdata, he); end
        end
        if (host_valid && host_ready) begin
            if (xq.size() == 0) chk("host_xfer_unexpected", 1, 0);
            else begin
                xe = xq.pop_front();
                chk("xfer_addr", sram_addr, xe.addr);
                chk("xfer_d", sram_d, xe.d);
                chk("xfer_cen", sram_cen, 0);
                chk("xfer_wen", sram_wen, xe.wen);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        logic [12:0] ra [3];
        logic [15:0] rd [3];
        for (int i = 0; i < 8192; i++) mem[i] = 16'h0;
        mem[13'h0010] = 16'hBEEF;
        mem[13'h0020] = 16'h5A5A;
        mem[13'h0030] = 16'hCAFE;

        rst = 1'b1; core_idle(); ext_pause = 1'b0;
        host_valid = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        next(); next();
        // Stimulus during reset must be ignored.
        ext_pause = 1'b1; host_valid = 1'b1; host_we = 1'b1; host_addr = 13'h5;
        core_op(0, 13'h10, 0);
        @(negedge clk);
        chk("rst_host_ready", host_ready, 0);
        chk("rst_core_pause", core_pause, 0);
        chk("rst_sram_cen", sram_cen, 1);
        chk("rst_sram_wen", sram_wen, 1);
        chk("rst_rvalids", {core_rvalid, host_rvalid}, 0);
        chk("rst_rdata", {core_rdata, host_rdata}, 0);
        chk("rst_arb_err", arb_err, 0);
        next();
        rst = 1'b0; ext_pause = 1'b0; host_valid = 1'b0; host_we = 1'b0; core_idle();
        next();

        // Core-only read
        core_op(0, 13'h0010, 0); cq.push_back(16'hBEEF);
        @(negedge clk);
        chk("t1_cen", sram_cen, 0);
        chk("t1_addr", sram_addr, 13'h0010);
        chk("t1_wen", sram_wen, 1);
        next(); core_idle();
        @(negedge clk);
        chk("t1_core_rvalid", core_rvalid, 1);
        chk("t1_core_rdata", core_rdata, 16'hBEEF);
        chk("t1_host_rvalid", host_rvalid, 0);
        next();

        // Idle core: host write then read-back, zero grant latency
        host_valid = 1'b1; host_we = 1'b1; host_addr = 13'h1FFF; host_wdata = 16'h1234;
        xq.push_back('{13'h1FFF, 16'h1234, 1'b0});
        @(negedge clk);
        chk("t2_ready_wr", host_ready, 1);
        next();
        host_we = 1'b0; host_wdata = 16'h0;
        xq.push_back('{13'h1FFF, 16'h0, 1'b1}); hq.push_back(16'h1234);
        @(negedge clk);
        chk("t2_ready_rd", host_ready, 1);
        next(); host_valid = 1'b0;
        @(negedge clk);
        chk("t2_host_rvalid", host_rvalid, 1);
        next();

        // Continuous core traffic: bounded wait gives the host cycle 5
        host_valid = 1'b1; host_we = 1'b0; host_addr = 13'h0030;
        for (int k = 0; k < 7; k++) begin
            if (k < 5) begin core_op(0, 13'h0020, 0); cq.push_back(16'h5A5A); end
            else core_idle();
            if (k == 5) begin xq.push_back('{13'h0030, 16'h0, 1'b1}); hq.push_back(16'hCAFE); end
            if (k == 6) host_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("t3_pause_c%0d", k), core_pause, k == 4);
            chk($sformatf("t3_ready_c%0d", k), host_ready, k == 5);
            chk($sformatf("t3_hrvalid_c%0d", k), host_rvalid, k == 6);
            next();
        end

        // Core access in HOST is dropped and flags arb_err
        host_valid = 1'b1; host_we = 1'b1; host_addr = 13'h0050; host_wdata = 16'h7777;
        for (int k = 0; k < 7; k++) begin
            if (k < 5) core_op(1, 13'h0041, 16'hDEAD);
            else if (k == 5) core_op(1, 13'h0040, 16'hF00D);
            else core_idle();
            if (k == 5) xq.push_back('{13'h0050, 16'h7777, 1'b0});
            if (k == 6) host_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("t4_ready_c%0d", k), host_ready, k == 5);
            chk($sformatf("t4_err_c%0d", k), arb_err, k == 6);
            next();
        end
        ra[0] = 13'h0040; rd[0] = 16'h0000;
        ra[1] = 13'h0041; rd[1] = 16'hDEAD;
        ra[2] = 13'h0050; rd[2] = 16'h7777;
        host_we = 1'b0; host_wdata = 16'h0;
        for (int i = 0; i < 3; i++) begin
            host_valid = 1'b1; host_addr = ra[i];
            xq.push_back('{ra[i], 16'h0, 1'b1}); hq.push_back(rd[i]);
            next();
        end
        host_valid = 1'b0;
        next(); next();
        @(negedge clk);
        chk("t4_err_sticky", arb_err, 1);
        next();

        // ext_pause: back-to-back host writes, no waiting
        ext_pause = 1'b1; core_idle(); host_we = 1'b1;
        for (int k = 0; k < 3; k++) begin
            host_valid = 1'b1; host_addr = 13'h0100 + 13'(k); host_wdata = 16'hA1 + 16'(k);
            xq.push_back('{13'h0100 + 13'(k), 16'hA1 + 16'(k), 1'b0});
            @(negedge clk);
            chk($sformatf("t5_ready_%0d", k), host_ready, 1);
            chk($sformatf("t5_pause_%0d", k), core_pause, 1);
            chk($sformatf("t5_wcnt_%0d", k), dut.wcnt, 0);
            next();
        end
        ext_pause = 1'b0; host_valid = 1'b0;
        @(negedge clk);
        chk("t5_pause_off", core_pause, 0);
        next();

        // Reset right after a host read grant discards the read
        host_valid = 1'b1; host_we = 1'b0; host_addr = 13'h0100; host_wdata = 16'h0;
        xq.push_back('{13'h0100, 16'h0, 1'b1});
        @(negedge clk);
        chk("t6_ready", host_ready, 1);
        next(); rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_hrvalid", host_rvalid, 0);
        chk("t6_rst_ready", host_ready, 0);
        chk("t6_rst_cen", sram_cen, 1);
        next(); rst = 1'b0; host_valid = 1'b0;
        @(negedge clk);
        chk("t6_post_hrvalid", host_rvalid, 0);
        chk("t6_post_err", arb_err, 0);
        chk("t6_post_pins", {sram_cen, sram_wen}, 2'b11);
        chk("t6_post_pause", core_pause, 0);
        next(); next();

        chk("cq_empty", cq.size(), 0);
        chk("hq_empty", hq.size(), 0);
        chk("xq_empty", xq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
